// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel between NUM_REQ requesters, with packet locking.
// Optional forced release of a stalled owner is built when ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          pick_found;
    logic          transfer;
    logic          last_xfer;
    logic          timeout_hit;

    // Search starts just after the last owner so it becomes lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick       = rr_ptr;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        req_ready     = '0;
        if (state == LOCK) begin
            tx_data          = req_data[{owner, 3'b000} +: 8];
            tx_data_valid    = req_valid[owner];
            req_ready[owner] = tx_data_ready;
        end
    end

    assign transfer  = tx_data_valid && tx_data_ready;
    assign last_xfer = transfer && req_last[owner];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            busy   <= 1'b0;
            owner  <= '0;
            rr_ptr <= IW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state <= LOCK;
                        owner <= pick;
                        grant <= NUM_REQ'(1) << pick;
                        busy  <= 1'b1;
                    end
                end
                LOCK: begin
                    if (last_xfer || timeout_hit) begin
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // The release fires on the cycle that completes TIMEOUT_CYCLES idle owner cycles.
    assign timeout_hit = (state == LOCK) && !req_valid[owner] &&
                         (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (state != LOCK || req_valid[owner] || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table for the main flows plus hand sequences
// for stalled-owner handling and a 40-byte round-robin fairness run.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_data     (req_data),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready),
        .grant        (grant),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        txr;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_grant;
        logic        exp_busy;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    function automatic void add(input logic r, input logic [3:0] v, input logic [3:0] l,
                                input logic [31:0] d, input logic t, input logic ev,
                                input logic [7:0] ed, input logic [3:0] er,
                                input logic [3:0] eg, input logic eb);
        vec_t x;
        x = '{r, v, l, d, t, ev, ed, er, eg, eb};
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns before the rising edge.
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d, input logic t);
        @(negedge clk);
        rst_n         = r;
        req_valid     = v;
        req_last      = l;
        req_data      = d;
        tx_data_ready = t;
        #4;
    endtask

    function automatic int onehot_idx(input logic [3:0] g);
        int idx;
        idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) idx = i;
        end
        return idx;
    endfunction

    initial begin
        int   cnt[4];
        int   cycles;
        logic hold_ok;
        logic [7:0] e;

        // reset state
        add(1, 4'b0000, 4'b0000, 32'h0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        // req0 sends 0x41,0x42,0x43
        add(1, 4'b0001, 4'b0000, 32'h41, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b0001, 4'b0000, 32'h41, 1, 1, 8'h41, 4'h1, 4'h1, 1);
        add(1, 4'b0001, 4'b0000, 32'h42, 1, 1, 8'h42, 4'h1, 4'h1, 1);
        add(1, 4'b0001, 4'b0001, 32'h43, 1, 1, 8'h43, 4'h1, 4'h1, 1);
        add(1, 4'b0000, 4'b0000, 32'h0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        // reset, then req0 and req2 contend: order 0,2,0,2 with a bubble between
        add(0, 4'b0000, 4'b0000, 32'h0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b0101, 4'b0101, 32'h00C0_00A0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b0101, 4'b0101, 32'h00C0_00A0, 1, 1, 8'hA0, 4'h1, 4'h1, 1);
        add(1, 4'b0101, 4'b0101, 32'h00C0_00A0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b0101, 4'b0101, 32'h00C0_00A0, 1, 1, 8'hC0, 4'h4, 4'h4, 1);
        add(1, 4'b0101, 4'b0101, 32'h00C0_00A0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b0101, 4'b0101, 32'h00C0_00A0, 1, 1, 8'hA0, 4'h1, 4'h1, 1);
        add(1, 4'b0101, 4'b0101, 32'h00C0_00A0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b0101, 4'b0101, 32'h00C0_00A0, 1, 1, 8'hC0, 4'h4, 4'h4, 1);
        add(1, 4'b0000, 4'b0000, 32'h0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        // req1 4-byte packet with ready 1,0,0,1 while req3 waits
        add(1, 4'b0010, 4'b0000, 32'h0000_1100, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b1010, 4'b1000, 32'h3300_1100, 1, 1, 8'h11, 4'h2, 4'h2, 1);
        add(1, 4'b1010, 4'b1000, 32'h3300_1200, 0, 1, 8'h12, 4'h0, 4'h2, 1);
        add(1, 4'b1010, 4'b1000, 32'h3300_1200, 0, 1, 8'h12, 4'h0, 4'h2, 1);
        add(1, 4'b1010, 4'b1000, 32'h3300_1200, 1, 1, 8'h12, 4'h2, 4'h2, 1);
        add(1, 4'b1010, 4'b1000, 32'h3300_1300, 1, 1, 8'h13, 4'h2, 4'h2, 1);
        add(1, 4'b1010, 4'b1010, 32'h3300_1400, 1, 1, 8'h14, 4'h2, 4'h2, 1);
        add(1, 4'b1000, 4'b1000, 32'h3300_0000, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b1000, 4'b1000, 32'h3300_0000, 1, 1, 8'h33, 4'h8, 4'h8, 1);
        add(1, 4'b0000, 4'b0000, 32'h0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        // move rr_ptr to 0, then reset in the middle of a req1 packet
        add(1, 4'b0001, 4'b0001, 32'h0000_00A0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b0001, 4'b0001, 32'h0000_00A0, 1, 1, 8'hA0, 4'h1, 4'h1, 1);
        add(1, 4'b0000, 4'b0000, 32'h0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b0010, 4'b0000, 32'h0000_5100, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b0010, 4'b0000, 32'h0000_5100, 1, 1, 8'h51, 4'h2, 4'h2, 1);
        add(1, 4'b0010, 4'b0000, 32'h0000_5200, 1, 1, 8'h52, 4'h2, 4'h2, 1);
        add(0, 4'b0010, 4'b0000, 32'h0000_5300, 1, 1, 8'h53, 4'h2, 4'h2, 1);
        // rr_ptr back at NUM_REQ-1: req0 beats req1
        add(1, 4'b0011, 4'b0011, 32'h0000_53A0, 1, 0, 8'h00, 4'h0, 4'h0, 0);
        add(1, 4'b0011, 4'b0011, 32'h0000_53A0, 1, 1, 8'hA0, 4'h1, 4'h1, 1);
        add(1, 4'b0000, 4'b0000, 32'h0, 1, 0, 8'h00, 4'h0, 4'h0, 0);

        rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_data_ready = 1'b1;
        repeat (2) drive(0, 4'b0000, 4'b0000, 32'h0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].txr);
            check($sformatf("row%0d tx_data_valid", i), 32'(tx_data_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("row%0d tx_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
            check($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            check($sformatf("row%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("row%0d timeout_err", i), 32'(timeout_err), 32'd0);
        end

        // owner req2 stalls mid-packet while req3 waits (rr_ptr=0 here)
        drive(1, 4'b1100, 4'b0000, 32'hD1C1_0000, 1);
        drive(1, 4'b1100, 4'b0000, 32'hD1C1_0000, 1);
        check("stall first byte", 32'(tx_data), 32'hC1);
        check("stall grant", 32'(grant), 32'h4);
        hold_ok = 1'b1;
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            drive(1, 4'b1000, 4'b0000, 32'hD1C1_0000, 1);
            if (grant !== 4'b0100 || timeout_err !== 1'b0 || req_ready[3] !== 1'b0) hold_ok = 1'b0;
        end
        check("timeout hold window", 32'(hold_ok), 32'd1);
        drive(1, 4'b1000, 4'b1000, 32'hD1C1_0000, 1);
        check("timeout_err pulse", 32'(timeout_err), 32'd1);
        check("timeout grant released", 32'(grant), 32'h0);
        check("timeout busy", 32'(busy), 32'd0);
        drive(1, 4'b1000, 4'b1000, 32'hD1C1_0000, 1);
        check("timeout_err one cycle", 32'(timeout_err), 32'd0);
        check("req3 after timeout", 32'(grant), 32'h8);
        check("req3 byte", 32'(tx_data), 32'hD1);
`else
        for (int k = 1; k <= 1000; k++) begin
            drive(1, 4'b1000, 4'b0000, 32'hD1C1_0000, 1);
            if (grant !== 4'b0100 || timeout_err !== 1'b0 || req_ready[3] !== 1'b0 ||
                tx_data_valid !== 1'b0) hold_ok = 1'b0;
        end
        check("grant held 1000 cycles", 32'(hold_ok), 32'd1);
        drive(1, 4'b1100, 4'b0100, 32'hD1C2_0000, 1);
        check("resumed last byte", 32'(tx_data), 32'hC2);
        check("resumed valid", 32'(tx_data_valid), 32'd1);
        drive(1, 4'b1000, 4'b1000, 32'hD1C2_0000, 1);
        check("bubble after release", 32'(grant), 32'h0);
        drive(1, 4'b1000, 4'b1000, 32'hD1C2_0000, 1);
        check("req3 after release", 32'(grant), 32'h8);
        check("req3 byte", 32'(tx_data), 32'hD1);
`endif
        drive(1, 4'b0000, 4'b0000, 32'h0, 1);
        check("idle after stall case", 32'(busy), 32'd0);

        // all four requesters stream 1-byte packets; expect 0,1,2,3 order, 10 each
        for (int b = 0; b < 40; b++) exp_q.push_back({4'(b % 4), 4'(b / 4)});
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 200) begin
            drive(1, 4'b1111, 4'b1111,
                  {4'd3, 4'(cnt[3]), 4'd2, 4'(cnt[2]), 4'd1, 4'(cnt[1]), 4'd0, 4'(cnt[0])}, 1);
            cycles++;
            if (tx_data_valid === 1'b1) begin
                e = exp_q.pop_front();
                check("rr byte", 32'(tx_data), 32'(e));
                check("rr grant", 32'(grant), 32'(4'b0001 << e[7:4]));
                if (onehot_idx(grant) >= 0) cnt[onehot_idx(grant)]++;
            end
        end
        check("rr stream complete", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("rr count req%0d", i), 32'(cnt[i]), 32'd10);
        drive(1, 4'b0000, 4'b0000, 32'h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
